// File: rtl/multu_hilo_pkg.sv
// Shared definitions for the Hi/Lo multiplier and the datapath output mux:
// operand width and the 6-bit funct codes both blocks decode.
package multu_hilo_pkg;

    localparam int WORD_WIDTH = 32;

    // Hi/Lo group
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    // ALU group
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    // Shift group
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV  = 6'b000111;

    function automatic logic is_hilo_write(input logic [5:0] funct);
        return (funct == FUNCT_MULTU) || (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/multu_hilo_step_adder.sv
// One shift-add step: (W+1)-bit conditional add of the multiplicand onto the
// upper product half, keeping the carry for the following right shift.
module mul_step_adder
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH:0]   upper,
    input  logic [WIDTH-1:0] addend,
    input  logic             add_en,
    output logic [WIDTH:0]   sum
);

    always_comb begin
        sum = upper;
        if (add_en) begin
            sum = upper + {1'b0, addend};
        end
    end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier owning the architectural Hi/Lo pair;
// also services MTHI/MTLO writes when no multiply is in flight.
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   prod;
    logic [2*WIDTH:0]   prod_next;
    logic [WIDTH:0]     step_sum;
    logic [CNT_W-1:0]   counter;
    logic               accept;
    logic               cmd_multu;
    logic               cmd_mthi;
    logic               cmd_mtlo;
    logic               last_iter;

    // Commands are only honoured outside RUN; a strobe during a multiply is dropped.
    assign accept    = start && (state != RUN) && is_hilo_write(Signal);
    assign cmd_multu = accept && (Signal == FUNCT_MULTU);
    assign cmd_mthi  = accept && (Signal == FUNCT_MTHI);
    assign cmd_mtlo  = accept && (Signal == FUNCT_MTLO);
    assign last_iter = (state == RUN) && (counter == CNT_W'(WIDTH - 1));

    mul_step_adder #(
        .WIDTH (WIDTH)
    ) u_step_adder (
        .upper  (prod[2*WIDTH:WIDTH]),
        .addend (mcand),
        .add_en (prod[0]),
        .sum    (step_sum)
    );

    assign prod_next = {1'b0, step_sum, prod[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = cmd_multu ? RUN : IDLE;
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Hi/Lo only move on completion or an explicit move; the product lives in prod until then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            prod    <= '0;
            counter <= '0;
            HiOut   <= '0;
            LoOut   <= '0;
        end else begin
            if (cmd_multu) begin
                mcand   <= dataA;
                prod    <= {1'b0, {WIDTH{1'b0}}, dataB};
                counter <= '0;
            end else if (state == RUN) begin
                prod    <= prod_next;
                counter <= counter + 1'b1;
                if (last_iter) begin
                    HiOut <= prod_next[2*WIDTH-1:WIDTH];
                    LoOut <= prod_next[WIDTH-1:0];
                end
            end
            if (cmd_mthi) begin
                HiOut <= dataA;
            end
            if (cmd_mtlo) begin
                LoOut <= dataA;
            end
        end
    end

endmodule
